// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_unit
// Description : Multi-cycle multiply/divide unit owning the HI/LO pair.
//               Iterative shift-add multiplier and restoring divider working
//               on operand magnitudes, with a one-cycle sign fix-up stage.
//               A start/busy/done handshake lets the control FSM stall on
//               MFHI/MFLO until the result lands.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   operand width; hi and lo are each WIDTH bits (WIDTH >= 4)
// Optional feature macro
//   MULDIV_FAST_MUL_EN  single-cycle MULT/MULTU (hi/lo written at the start
//                       edge, done pulses in the next cycle, busy stays low)
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset; aborts any op in flight
//   start   in   request, sampled only while busy is low
//   op      in   0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO 6,7=no-op
//   src_a   in   multiplicand / dividend / MTHI-MTLO data
//   src_b   in   multiplier / divisor
//   busy    out  operation in flight
//   done    out  one-cycle pulse: hi/lo hold a fresh mul/div result
//   hi      out  HI register (product upper half / remainder)
//   lo      out  LO register (product lower half / quotient)
// ============================================================================
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc_hi/acc_lo: partial product pair (mul) or remainder/quotient (div)
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder
    logic             divz_q, divz_d;         // divisor was zero

    // ------------------------------------------------------------------
    // Operand conditioning at the start edge
    // ------------------------------------------------------------------
    logic             w_sgn_op;
    logic             w_neg_res;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_sgn_op  = op[0];
    assign w_neg_res = w_sgn_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    // MIN negates to itself, which is exactly its unsigned magnitude
    assign w_abs_a   = (w_sgn_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_abs_b   = (w_sgn_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;      // shift-add with carry out
    logic [WIDTH:0]     w_rem_sh;   // remainder shifted with next dividend bit
    logic [WIDTH:0]     w_diff;     // trial subtraction, MSB is the borrow
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, opnd_q};

    assign w_prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    // A zero divisor leaves the magnitude quotient all-ones; force it so the
    // signed negation cannot turn it into 1.
    assign w_quo_fix  = divz_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
    assign w_rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_mag;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_fast_mag  = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
    assign w_fast_prod = w_neg_res ? -w_fast_mag : w_fast_mag;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE lasts exactly one cycle unless a new op is accepted
                state_d = S_IDLE;
                if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            is_div_d  = op[1];
                            neg_res_d = w_neg_res;
                            neg_rem_d = w_sgn_op & src_a[WIDTH-1];
                            divz_d    = op[1] & (src_b == '0);
                            cnt_d     = '0;
                            acc_hi_d  = '0;
                            if (op[1]) begin
                                acc_lo_d = w_abs_a;   // dividend shifts out MSB-first
                                opnd_d   = w_abs_b;
                            end else begin
                                acc_lo_d = w_abs_b;   // multiplier shifts out LSB-first
                                opnd_d   = w_abs_a;
                            end
                            state_d = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
                            if (!op[1]) begin
                                hi_d    = w_fast_prod[2*WIDTH-1:WIDTH];
                                lo_d    = w_fast_prod[WIDTH-1:0];
                                state_d = S_DONE;
                            end
`endif
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!w_diff[WIDTH]) begin
                        acc_hi_d = w_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = w_rem_sh[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = w_sum[WIDTH:1];
                    acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
